// File: rtl/c20_pipe.sv
// c20_pipe: pipelined multi-channel C20 cone with valid/ready, delivered-vector count and optional MISR (C20_PIPE_MISR_EN)
module c20_pipe #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 16,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h002D
) (
  input  logic                    CK,
  input  logic                    RSTn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*CHANNELS-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*CHANNELS-1:0]   out_data,
  input  logic                    clear,
  output logic [CNT_W-1:0]        vec_count,
  output logic [SIG_W-1:0]        signature
);
  logic en, v1, v2, v3, delivered;
  assign en = ~v3 | out_ready;
  assign in_ready = en;
  assign out_valid = v3;
  assign delivered = v3 & out_ready;
  always_ff @(posedge CK or negedge RSTn)
    if (!RSTn) {v1, v2, v3} <= '0;
    else if (en) {v1, v2, v3} <= {in_valid, v1, v2};
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [15:0] gi;
    logic a, b, c, d, e, f, g1, p, q, r, g2, x, fo;
    assign gi = in_data[16*k +: 16];
    // F is redundant by construction; every term is kept as its own register
    always_ff @(posedge CK or negedge RSTn)
      if (!RSTn) {a, b, c, d, e, f, g1, p, q, r, g2, x, fo} <= '0;
      else if (en) begin
        a  <= gi[0] & gi[1];
        b  <= gi[2] | gi[3] | gi[4];
        c  <= gi[5] & gi[6] & gi[7] & gi[8];
        d  <= gi[9] | gi[10];
        e  <= gi[11] & gi[12];
        f  <= ~(gi[13] & gi[14]);
        g1 <= gi[15];
        p  <= a & b & c;
        q  <= ~c;
        r  <= d & e & f;
        g2 <= g1;
        x  <= q ^ r;
        fo <= ~(p & (q ^ r)) | (q ^ r) | (~q & ~r & g2);
      end
    assign out_data[2*k]   = fo;
    assign out_data[2*k+1] = x;
  end
  always_ff @(posedge CK or negedge RSTn)
    if (!RSTn) vec_count <= '0;
    else if (clear) vec_count <= '0;
    else if (delivered && !(&vec_count)) vec_count <= vec_count + CNT_W'(1);
`ifdef C20_PIPE_MISR_EN
  always_ff @(posedge CK or negedge RSTn)
    if (!RSTn) signature <= '0;
    else if (clear) signature <= '0;
    else if (delivered)
      signature <= (signature << 1) ^ (signature[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(out_data);
`else
  assign signature = '0;
`endif
endmodule
